// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream and instruction-memory write bus for prog_loader
// master: host byte source and instruction store; slave: the loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 13
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader writing 13-bit words into instruction memory
// Optional trailing checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.slave      bus,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);
  localparam int HI_W = DATA_W - 8;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_FIN, S_CSUM} state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [HI_W-1:0]   hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic [7:0]        sum_q, sum_d;
  logic              sum_bad_q, sum_bad_d;
  logic              xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      wc_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      sum_q      <= '0;
      sum_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      wc_q       <= wc_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      sum_q      <= sum_d;
      sum_bad_q  <= sum_bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    wc_d      = wc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    sum_d     = sum_q;
    sum_bad_d = sum_bad_q;
    xfer      = bus.in_valid && in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          wc_d      = '0;
          addr_d    = '0;
          sum_d     = '0;
          sum_bad_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
          len_d   = bus.in_data;
          sum_d   = sum_q + bus.in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          if (bus.in_data[7:HI_W] != '0) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            hi_d    = bus.in_data[HI_W-1:0];
            sum_d   = sum_q + bus.in_data;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {hi_q, bus.in_data};
          addr_d    = addr_q + 1'b1;
          wc_d      = wc_q + 1'b1;
          sum_d     = sum_q + bus.in_data;
          // wc_q still counts the words before this one, so equality with L marks word N
          if (wc_q == (ADDR_W+1)'(len_q)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_FIN;
`endif
          end else begin
            state_d = S_HI;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          sum_bad_d = (sum_q + bus.in_data) != 8'd0;
          state_d   = S_FIN;
        end
      end
`endif
      S_FIN: begin
        // hold until the final write strobe has retired, then report
        if (!wr_en_q) begin
          busy_d  = 1'b0;
          done_d  = !sum_bad_q;
          err_d   = sum_bad_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
                 (state_d == S_LO)  || (state_d == S_CSUM);
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = wc_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
// Stream-level reference model; directed plus randomized loads.
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 13;

  typedef logic [7:0] byte_q_t [$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, err;
  logic [ADDR_W:0]   word_count;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .word_count_o (word_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [20:0] got_w [$];
  logic [20:0] exp_w [$];
  logic        exp_done, exp_err, exp_abort;
  int          exp_wc, exp_used;

  always @(negedge clk)
    if (bus.wr_en === 1'b1) got_w.push_back({bus.wr_addr, bus.wr_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Parse a stream by its rules: length, word pairs, abort on bad high byte, optional checksum.
  task automatic model_load(input byte_q_t s);
    int n, idx;
    logic [7:0] sum;
    exp_w.delete();
    exp_done = 0; exp_err = 0; exp_abort = 0; exp_wc = 0;
    n = int'(s[0]) + 1;
    sum = s[0];
    idx = 1;
    for (int w = 0; w < n; w++) begin
      if (s[idx] > 8'd31) begin
        exp_err = 1; exp_abort = 1; exp_used = idx + 1;
        return;
      end
      exp_w.push_back({8'(w), s[idx][4:0], s[idx+1]});
      sum = sum + s[idx] + s[idx+1];
      idx += 2;
      exp_wc++;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    sum = sum + s[idx];
    idx++;
    exp_done = (sum == 8'd0);
    exp_err  = !exp_done;
`else
    exp_done = 1;
`endif
    exp_used = idx;
  endtask

  function automatic byte_q_t with_csum(input byte_q_t s, input bit bad);
    byte_q_t r;
    logic [7:0] sum;
    r = s;
    sum = 8'd0;
    foreach (s[i]) sum = sum + s[i];
`ifdef PROG_LOADER_CHECKSUM_EN
    r.push_back(8'(8'd0 - sum) + (bad ? 8'd1 : 8'd0));
`else
    if (bad) r = s;
`endif
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input string tag, input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check({tag, ":ready_timeout"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_load(input string tag, input byte_q_t s, input int gmin, input int gmax);
    int cyc, lat;
    model_load(s);
    got_w.delete();
    // first byte offered alongside start must not be taken in IDLE
    bus.in_valid = 1'b1;
    bus.in_data  = s[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < exp_used; i++)
      send_byte(tag, s[i], (gmax == 0) ? 0 : int'($urandom_range(gmax, gmin)));
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!(done || err) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    lat = exp_abort ? 1 : 2;
`else
    lat = exp_abort ? 1 : 3;
`endif
    check({tag, ":latency"}, 32'(cyc), 32'(lat));
    repeat (2) @(negedge clk);
    check({tag, ":done"}, 32'(done), 32'(exp_done));
    check({tag, ":err"}, 32'(err), 32'(exp_err));
    check({tag, ":busy_end"}, 32'(busy), 32'd0);
    check({tag, ":word_count"}, 32'(word_count), 32'(exp_wc));
    check({tag, ":n_writes"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      check($sformatf("%s:write%0d", tag, i),
            (i < got_w.size()) ? 32'(got_w[i]) : 32'hFFFF_FFFF, 32'(exp_w[i]));
    if (exp_w.size() > 0) begin
      check({tag, ":wr_en_idle"}, 32'(bus.wr_en), 32'd0);
      check({tag, ":bus_hold"}, 32'({bus.wr_addr, bus.wr_data}), 32'(exp_w[exp_w.size()-1]));
    end
  endtask

  initial begin
    byte_q_t basic, s;
    logic [7:0] b;

    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t basic, s;
    logic [7:0] b;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    basic = '{8'h02, 8'h11, 8'h00, 8'h12, 8'h00, 8'h00, 8'h01};

    #1;
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:err", 32'(err), 32'd0);
    check("reset:word_count", 32'(word_count), 32'd0);
    check("reset:in_ready", 32'(bus.in_ready), 32'd0);
    check("reset:wr_bus", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // no start: bytes in IDLE are ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h02;
    repeat (4) begin
      @(negedge clk);
      check("idle:in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("idle:busy", 32'(busy), 32'd0);

    run_load("basic", with_csum(basic, 0), 0, 0);
    run_load("gaps", with_csum(basic, 0), 1, 3);
    check("gaps:three_pulses", 32'(got_w.size()), 32'd3);

    s = '{8'h00, 8'h21, 8'h05};
    run_load("badhi", s, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    repeat (4) begin
      @(negedge clk);
      check("badhi:byte05_refused", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("badhi:no_write", 32'(got_w.size()), 32'd0);

    s = '{8'hFF};
    for (int i = 0; i < 256; i++) begin
      s.push_back(8'((i ^ 'h0AA) >> 8));
      s.push_back(8'(i ^ 'h0AA));
    end
    run_load("full", with_csum(s, 0), 0, 0);
    check("full:last_addr_data", 32'({bus.wr_addr, bus.wr_data}), 32'({8'hFF, 13'h055}));
    check("full:word_count", 32'(word_count), 32'd256);

    for (int it = 0; it < 4; it++) begin
      s = '{};
      b = 8'($urandom_range(12, 0));
      s.push_back(b);
      for (int w = 0; w <= int'(b); w++) begin
        s.push_back(8'($urandom_range(31, 0)));
        s.push_back(8'($urandom_range(255, 0)));
      end
      run_load($sformatf("rand%0d", it), with_csum(s, it[0]), 0, 2);
    end

    // asynchronous reset between high and low byte of the second word
    got_w.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte("rstmid", basic[i], 0);
    #2 rst = 1'b1;
    #1;
    check("rstmid:busy", 32'(busy), 32'd0);
    check("rstmid:in_ready", 32'(bus.in_ready), 32'd0);
    check("rstmid:word_count", 32'(word_count), 32'd0);
    check("rstmid:wr_bus", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid:n_writes", 32'(got_w.size()), 32'd1);
    check("rstmid:first_write", (got_w.size() > 0) ? 32'(got_w[0]) : 32'hFFFF_FFFF,
          32'({8'h00, 13'h1100}));
    run_load("reload", with_csum(basic, 0), 0, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    run_load("csum_bad", with_csum(basic, 1), 0, 0);
    check("csum_bad:writes", 32'(got_w.size()), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the processor's 13-bit instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles 13-bit instruction words, and issues one-cycle write strobes at sequential addresses starting at 0.
- Sits between a host byte source (UART or debug port) and the writable instruction store read by the fetch stage, so programs load at run time instead of being fixed in the case table.

Parameters:
- ADDR_W, 8, instruction address width; memory depth is 2**ADDR_W words.
- DATA_W, 13, instruction word width; high byte carries bits [DATA_W-1:8].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  DATA_W  write data.
- busy  output  1  load in progress.
- done  output  1  last load completed cleanly; sticky until next start.
- err  output  1  last load aborted or failed; sticky until next start.
- word_count  output  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0 immediately and state goes to IDLE. A reset mid-load kills any pending wr_en in the same instant; memory already written is not undone.
- Handshake: a byte transfers on a rising edge when in_valid && in_ready. in_ready is a registered function of state only, with no combinational path from in_valid.
- Stream format:
  - One length byte L; word count N = L+1 (range 1..256).
  - Then N pairs of bytes: high byte first, then low byte.
- IDLE:
  - in_ready=0, busy=0.
  - start: clears done, err, word_count and the address counter; sets busy=1; next state LEN.
  - start while busy is ignored.
  - A byte presented in the same cycle as start is not accepted.
- LEN: in_ready=1. On transfer, latch N; next state HI.
- HI: in_ready=1. On transfer:
  - If in_data[7:DATA_W-8] != 0: set err=1, busy=0, state IDLE (abort). No write occurs for this word.
  - Otherwise latch in_data[DATA_W-9:0]; next state LO.
- LO: in_ready=1. On transfer:
  - Next cycle: wr_en=1 for exactly one cycle, wr_addr = address counter, wr_data = {hi_bits, lo_byte}.
  - In that same cycle word_count increments and the address counter increments, wrapping at 2**ADDR_W.
  - If this was word N: next state FIN. Otherwise next state HI; the next byte may be accepted while wr_en is high.
- FIN: in_ready=0. After one cycle: busy=0, done=1, state IDLE.
- Latency: last low byte handshake at edge k; wr_en high in cycle k+1; done high from edge k+2.
- Boundary conditions:
  - With N=256 the final write is to address 0xFF; the address counter wraps to 0 and word_count reads 256.
  - wr_addr and wr_data hold their last values when wr_en=0.
  - in_valid with no start in IDLE or FIN is ignored indefinitely.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After word N, state CSUM with in_ready=1 accepts one checksum byte.
  - The 8-bit modulo-256 sum of the length byte, all data bytes, and the checksum byte must equal 0x00. Match gives done=1; mismatch gives err=1, done=0.
  - Writes already issued remain.
  - Timing: done or err asserts one cycle after the checksum handshake; busy falls at the same time.
- Undefined: no CSUM state; behaviour exactly as above.

Test Plan:
- Basic load: start, then bytes 02 11 00 12 00 00 01, in_valid held high. Expect:
  - wr_en pulses at addr 0/1/2 with data 0x1100/0x1200/0x0001.
  - done=1, err=0, word_count=3.
  - With the macro defined, append checksum byte 0xDA and expect the same result.
- Backpressure and gaps: same stream with in_valid deasserted 1–3 random cycles between bytes. Expect identical writes; no byte is lost or duplicated; exactly 3 wr_en pulses.
- Bad high byte: start, bytes 00 21 05. Expect:
  - err=1, done=0, busy=0, no wr_en.
  - Byte 05 is not accepted (in_ready=0).
- Full depth: L=0xFF, 256 words of data i ^ 0x0AA. Expect the last write at addr 0xFF with data 0x055, word_count=256, done=1.
- Reset mid-load: assert rst asynchronously between the high and low byte of word 2. Expect:
  - All outputs 0 at once; no wr_en for word 2.
  - A subsequent start-plus-stream loads from address 0.
- Checksum mismatch (macro defined): basic stream with checksum 0xDB. Expect 3 writes, err=1, done=0.
